binary_region_stats: RTL and testbench
======================================

Name: binary_region_stats

Overview:
- Sink-side consumer of the binary video stream produced by the morphological erosion/dilation stage.
- Reads the per-pixel bit stream (vsync/href/clken/bit) of one frame and computes pixel coordinates, the foreground bounding box and the foreground area (pixel count).
- Latches per-frame results at frame end for the downstream overlay/classification logic; raises a one-cycle result strobe.

Parameters:
- IMG_W, 640, active pixels per line; x positions >= IMG_W are ignored.
- IMG_H, 480, active lines per frame; y positions >= IMG_H are ignored.
- XW, 11, x coordinate width.
- YW, 10, y coordinate width.
- CNT_W, 20, area counter width; saturates at 2^CNT_W-1.
- MIN_AREA, 200, minimum area for obj_found=1.

Ports:
- pixelclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sampled at frame start; 0 = ignore the whole frame.
- per_frame_vsync  in  1  high for the duration of a frame.
- per_frame_href  in  1  high during an active line.
- per_frame_clken  in  1  pixel valid qualifier.
- per_img_Bit  in  1  1 = foreground pixel.
- box_x_min  out  XW  leftmost foreground x of the last completed frame.
- box_x_max  out  XW  rightmost foreground x.
- box_y_min  out  YW  top foreground y.
- box_y_max  out  YW  bottom foreground y.
- area  out  CNT_W  foreground pixel count, saturating.
- obj_found  out  1  area >= MIN_AREA.
- result_valid  out  1  one-cycle strobe when outputs update.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and accumulators cleared.
- Input stage: vsync, href, clken and bit registered once. Edges are detected on the registered vsync and href.
- FSM states:
  - IDLE to ACTIVE on vsync rising edge when en=1. With en=0, stay in IDLE and ignore the frame.
  - ACTIVE to DONE on vsync falling edge.
  - DONE to IDLE unconditionally after 1 cycle.
- ACTIVE, per qualified pixel (reg href=1 and reg clken=1):
  - x counts from 0 and increments per qualified pixel, saturating at IMG_W.
  - On href falling edge: x cleared; y increments, saturating at IMG_H.
  - y is 0 on the first line.
- Accumulation: a qualified pixel with bit=1, x<IMG_W and y<IMG_H does all of the following:
  - area_acc += 1, saturating.
  - x_min = min(x_min, x); x_max = max(x_max, x).
  - y_min = min(y_min, y); y_max = max(y_max, y).
- Accumulator init at frame start: x_min=all ones, y_min=all ones, x_max=0, y_max=0, area_acc=0.
- DONE: outputs latched from the accumulators; result_valid=1 for exactly this cycle.
  - Latency: result_valid rises 2 pixelclk after the first cycle per_frame_vsync is sampled low.
- Empty frame (area_acc=0): all box outputs 0, area=0, obj_found=0. Never output the all-ones init values.
- obj_found = (area_acc >= MIN_AREA), latched together with the other outputs.
- Outputs hold their values between strobes. Ignored frames (en=0) leave the outputs unchanged and raise no strobe.
- Simultaneous events:
  - href falling edge and vsync falling edge in the same cycle: the last pixel is still accumulated, then DONE.
  - vsync rising edge while in DONE is lost; the next frame is missed. Upstream guarantees vsync low for at least 2 cycles.
- Reset mid-frame: immediate return to IDLE and outputs cleared. The partial frame is discarded; the next full frame is processed normally.
- clken low inside href: no x advance, no accumulation.

Test Plan:
- 8x4 frame (IMG_W=8, IMG_H=4, MIN_AREA=3), foreground at (2,1),(5,1),(3,2) -> box 2..5 / 1..2, area=3, obj_found=1, result_valid pulse of 1 cycle, 2 clocks after vsync low.
- All-zero frame -> box outputs 0, area=0, obj_found=0, result_valid pulses.
- en=0 at vsync rise with a full-white frame -> no result_valid, outputs keep the previous frame's values.
- All-ones frame IMG_W=8, IMG_H=4, CNT_W=4 -> box 0..7 / 0..3, area=15 (saturated), obj_found=1.
- Line of 10 clken pulses with IMG_W=8, bit=1 on all -> only x=0..7 counted, area=8, x_max=7.
- rst_n asserted mid-frame after 5 foreground pixels, released, then a frame with one pixel at (1,1) -> outputs 0 during reset, next result area=1, box 1..1 / 1..1.

Source files
------------

// File: rtl/binary_region_stats_if.sv
// Binary pixel stream in, per-frame region statistics out.
// master = stream source / result consumer, slave = statistics block.
interface binary_region_stats_if #(
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int CNT_W = 20
);
  logic             en;
  logic             per_frame_vsync;
  logic             per_frame_href;
  logic             per_frame_clken;
  logic             per_img_Bit;
  logic [XW-1:0]    box_x_min;
  logic [XW-1:0]    box_x_max;
  logic [YW-1:0]    box_y_min;
  logic [YW-1:0]    box_y_max;
  logic [CNT_W-1:0] area;
  logic             obj_found;
  logic             result_valid;

  modport master (
    output en, per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
    input  box_x_min, box_x_max, box_y_min, box_y_max, area, obj_found, result_valid
  );

  modport slave (
    input  en, per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
    output box_x_min, box_x_max, box_y_min, box_y_max, area, obj_found, result_valid
  );
endinterface

// File: rtl/binary_region_stats.sv
// Foreground bounding box and pixel count of one binary frame, latched at
// frame end with a one-cycle result strobe.
module binary_region_stats #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int CNT_W    = 20,
  parameter int MIN_AREA = 200
)(
  input  logic                  pixelclk,
  input  logic                  rst_n,
  binary_region_stats_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  typedef struct packed {
    logic en;
    logic vsync;
    logic href;
    logic clken;
    logic fg;
  } pix_t;

  localparam logic [XW-1:0]    X_LIM    = XW'(IMG_W);
  localparam logic [YW-1:0]    Y_LIM    = YW'(IMG_H);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // A threshold beyond the counter range can never be reached.
  localparam bit               MIN_OVER = (MIN_AREA >> CNT_W) != 0;
  localparam logic [CNT_W-1:0] MIN_A    = CNT_W'(MIN_AREA);

  pix_t             pix_r;
  logic             vs_d, hr_d;
  logic             vs_rise, vs_fall, hr_fall;
  state_t           state_q, state_d;
  logic             frame_start, latch;
  logic             pix_ok, in_win, hit;
  logic [XW-1:0]    x_q, x_min_q, x_max_q;
  logic [YW-1:0]    y_q, y_min_q, y_max_q;
  logic [CNT_W-1:0] area_q;

  // Input stage plus one more tap for edge detection.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_r <= '0;
      vs_d  <= 1'b0;
      hr_d  <= 1'b0;
    end else begin
      pix_r <= '{en:    bus.en,
                 vsync: bus.per_frame_vsync,
                 href:  bus.per_frame_href,
                 clken: bus.per_frame_clken,
                 fg:    bus.per_img_Bit};
      vs_d  <= pix_r.vsync;
      hr_d  <= pix_r.href;
    end
  end

  assign vs_rise = pix_r.vsync & ~vs_d;
  assign vs_fall = ~pix_r.vsync & vs_d;
  assign hr_fall = ~pix_r.href & hr_d;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    latch       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vs_rise && pix_r.en) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_fall) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        latch   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The pixel on the vsync-fall cycle is still accumulated before DONE.
  assign pix_ok = (state_q == ACTIVE) && pix_r.href && pix_r.clken;
  assign in_win = (x_q < X_LIM) && (y_q < Y_LIM);
  assign hit    = pix_ok && pix_r.fg && in_win;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      area_q  <= '0;
    end else if (frame_start) begin
      x_q     <= '0;
      y_q     <= '0;
      x_min_q <= '1;
      x_max_q <= '0;
      y_min_q <= '1;
      y_max_q <= '0;
      area_q  <= '0;
    end else if (state_q == ACTIVE) begin
      if (hr_fall) begin
        x_q <= '0;
        if (y_q != Y_LIM) y_q <= y_q + YW'(1);
      end else if (pix_ok && x_q != X_LIM) begin
        x_q <= x_q + XW'(1);
      end
      if (hit) begin
        if (area_q != CNT_MAX) area_q <= area_q + CNT_W'(1);
        if (x_q < x_min_q) x_min_q <= x_q;
        if (x_q > x_max_q) x_max_q <= x_q;
        if (y_q < y_min_q) y_min_q <= y_q;
        if (y_q > y_max_q) y_max_q <= y_q;
      end
    end
  end

  // Results are registered on the DONE cycle, so the strobe lands two
  // clocks after vsync is first sampled low.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.box_x_min    <= '0;
      bus.box_x_max    <= '0;
      bus.box_y_min    <= '0;
      bus.box_y_max    <= '0;
      bus.area         <= '0;
      bus.obj_found    <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= latch;
      if (latch) begin
        if (area_q == '0) begin
          bus.box_x_min <= '0;
          bus.box_x_max <= '0;
          bus.box_y_min <= '0;
          bus.box_y_max <= '0;
        end else begin
          bus.box_x_min <= x_min_q;
          bus.box_x_max <= x_max_q;
          bus.box_y_min <= y_min_q;
          bus.box_y_max <= y_max_q;
        end
        bus.area      <= area_q;
        bus.obj_found <= !MIN_OVER && (area_q >= MIN_A);
      end
    end
  end
endmodule

// File: tb/tb_binary_region_stats.sv
// Randomized frames checked against a pixel-list reference model through a
// result scoreboard.
module tb_binary_region_stats;
  localparam int IMG_W = 8, IMG_H = 4, XW = 4, YW = 3, CNT_W = 4, MIN_AREA = 3;
  localparam int AMAX = (1 << CNT_W) - 1;

  typedef struct {
    int x0, x1, y0, y1, a, obj, cyc;
  } res_t;

  logic pixelclk = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;
  int   errs     = 0;
  int   checks   = 0;
  res_t q[$];
  res_t held;
  res_t mon_e;
  logic rv_prev  = 1'b0;
  bit   fb[8][12];

  binary_region_stats_if #(.XW(XW), .YW(YW), .CNT_W(CNT_W)) bus();

  binary_region_stats #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW),
    .CNT_W(CNT_W), .MIN_AREA(MIN_AREA)
  ) dut (
    .pixelclk(pixelclk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 pixelclk = ~pixelclk;
  always @(posedge pixelclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input res_t e);
    chk({tag, "_x_min"}, int'(bus.box_x_min), e.x0);
    chk({tag, "_x_max"}, int'(bus.box_x_max), e.x1);
    chk({tag, "_y_min"}, int'(bus.box_y_min), e.y0);
    chk({tag, "_y_max"}, int'(bus.box_y_max), e.y1);
    chk({tag, "_area"},  int'(bus.area),      e.a);
    chk({tag, "_obj"},   int'(bus.obj_found), e.obj);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected frame.
  always @(negedge pixelclk) begin
    if (bus.result_valid) begin
      chk("strobe_width", int'(rv_prev), 0);
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_strobe: got result_valid=1 expected no strobe at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk_outputs("result", mon_e);
        chk("latency", cyc, mon_e.cyc);
      end
    end
    rv_prev = bus.result_valid;
  end

  // Reference: walk the frame as a list of lines of qualified pixels.
  function automatic res_t model(input int nl, input int np);
    res_t r;
    int a = 0, x0 = 1000, x1 = -1, y0 = 1000, y1 = -1;
    for (int y = 0; y < nl; y++)
      for (int x = 0; x < np; x++)
        if (fb[y][x] && x < IMG_W && y < IMG_H) begin
          a++;
          if (x < x0) x0 = x;
          if (x > x1) x1 = x;
          if (y < y0) y0 = y;
          if (y > y1) y1 = y;
        end
    r.a   = (a > AMAX) ? AMAX : a;
    r.obj = (r.a >= MIN_AREA) ? 1 : 0;
    r.cyc = 0;
    if (a == 0) begin
      r.x0 = 0; r.x1 = 0; r.y0 = 0; r.y1 = 0;
    end else begin
      r.x0 = x0; r.x1 = x1; r.y0 = y0; r.y1 = y1;
    end
    return r;
  endfunction

  task automatic clear_fb();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 12; x++) fb[y][x] = 1'b0;
  endtask

  task automatic drive_frame(input bit en_v, input int nl, input int np,
                             input bit gaps, input bit joint_end);
    res_t e;
    e = model(nl, np);
    @(negedge pixelclk);
    bus.en = en_v;
    bus.per_frame_vsync = 1'b1;
    repeat (3) @(negedge pixelclk);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < np; x++) begin
        bus.per_frame_href = 1'b1;
        if (gaps)
          while ($urandom_range(3) == 0) begin
            bus.per_frame_clken = 1'b0;
            bus.per_img_Bit     = 1'($urandom);
            @(negedge pixelclk);
          end
        bus.per_frame_clken = 1'b1;
        bus.per_img_Bit     = fb[y][x];
        @(negedge pixelclk);
      end
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      bus.per_img_Bit     = 1'b0;
      if (!(joint_end && y == nl - 1)) repeat (2) @(negedge pixelclk);
    end
    bus.per_frame_vsync = 1'b0;
    // Sampled low at the next edge; the strobe follows two edges later.
    e.cyc = cyc + 3;
    if (en_v) begin
      q.push_back(e);
      held = e;
    end
    repeat (6) @(negedge pixelclk);
    chk_outputs("hold", held);
  endtask

  initial begin
    res_t z;
    z = '{0, 0, 0, 0, 0, 0, 0};
    held = z;
    bus.en = 1'b0;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_Bit     = 1'b0;
    repeat (3) @(negedge pixelclk);
    chk_outputs("reset", z);
    chk("reset_valid", int'(bus.result_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge pixelclk);

    // Three sparse foreground pixels
    clear_fb();
    fb[1][2] = 1; fb[1][5] = 1; fb[2][3] = 1;
    drive_frame(1'b1, 4, 8, 1'b0, 1'b0);

    // Empty frame
    clear_fb();
    drive_frame(1'b1, 4, 8, 1'b1, 1'b0);

    // Ignored full-white frame, then a saturating full-white frame
    for (int y = 0; y < 8; y++) for (int x = 0; x < 12; x++) fb[y][x] = 1'b1;
    drive_frame(1'b0, 4, 8, 1'b0, 1'b0);
    drive_frame(1'b1, 4, 8, 1'b0, 1'b1);

    // Line longer than IMG_W
    drive_frame(1'b1, 1, 10, 1'b0, 1'b0);

    // Reset in the middle of a frame
    @(negedge pixelclk);
    bus.en = 1'b1;
    bus.per_frame_vsync = 1'b1;
    repeat (3) @(negedge pixelclk);
    bus.per_frame_href = 1'b1;
    for (int x = 0; x < 5; x++) begin
      bus.per_frame_clken = 1'b1;
      bus.per_img_Bit     = 1'b1;
      @(negedge pixelclk);
    end
    rst_n = 1'b0;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_Bit     = 1'b0;
    @(negedge pixelclk);
    chk_outputs("midreset", z);
    chk("midreset_valid", int'(bus.result_valid), 0);
    repeat (2) @(negedge pixelclk);
    rst_n = 1'b1;
    held = z;
    repeat (3) @(negedge pixelclk);
    clear_fb();
    fb[1][1] = 1;
    drive_frame(1'b1, 4, 8, 1'b0, 1'b0);

    // Random frames
    for (int n = 0; n < 24; n++) begin
      int dens;
      dens = $urandom_range(0, 3);
      clear_fb();
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 12; x++) fb[y][x] = ($urandom_range(3) < dens);
      drive_frame($urandom_range(5) != 0, $urandom_range(1, 6), $urandom_range(1, 11),
                  1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge pixelclk);
    if (q.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL pending_results: got %0d outstanding expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
